// File: rtl/key_deb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_deb_pkg
//  Description : Shared board constants for the key input conditioner:
//                system clock rate, default debounce / long-press windows
//                and the pull-up key polarity of the board.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_deb_pkg;

   // Board system clock
   localparam int unsigned c_clk_hz      = 25000000;

   // 20 ms stability window, expressed as (cycles - 1)
   localparam int unsigned c_deb_cnt     = (c_clk_hz / 1000) * 20 - 1;

   // 1 s long-press threshold, expressed as (cycles - 1)
   localparam int unsigned c_long_cnt    = c_clk_hz - 1;

   // Board keys have pull-ups: a pressed key reads 0
   localparam bit          c_key_act_low = 1'b1;

   // Map a raw pin level to "pressed = 1"
   function automatic logic f_norm(input logic raw, input bit act_low);
      return act_low ? ~raw : raw;
   endfunction

endpackage : key_deb_pkg
`default_nettype wire

// File: rtl/key_deb_ch.sv
`default_nettype none
// ============================================================================
//  Module      : key_deb_ch
//  Description : One key channel: 2-flop synchroniser, polarity normalise
//                stage, stability-window debounce with press/release pulses
//                and a saturating hold counter producing a one-shot
//                long-press pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_deb_ch
   import key_deb_pkg::*;
#(
   parameter int unsigned DEB_CNT     = c_deb_cnt,
   parameter int unsigned LONG_CNT    = c_long_cnt,
   parameter bit          KEY_ACT_LOW = c_key_act_low
)(
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic key_state,
   output logic key_press,
   output logic key_release,
   output logic key_long
);

   localparam int unsigned         c_deb_w   = $clog2(DEB_CNT + 1);
   localparam int unsigned         c_hold_w  = $clog2(LONG_CNT + 2);
   localparam logic [c_deb_w-1:0]  c_deb_max = c_deb_w'(DEB_CNT);
   localparam logic [c_hold_w-1:0] c_long_at = c_hold_w'(LONG_CNT);
   localparam logic [c_hold_w-1:0] c_hold_sat = c_hold_w'(LONG_CNT + 1);
   localparam logic                c_rel_lvl = KEY_ACT_LOW ? 1'b1 : 1'b0;

   logic [1:0]          r_sync;
   logic                r_syn;
   logic                r_state;
   logic                r_press;
   logic                r_release;
   logic                r_long;
   logic [c_deb_w-1:0]  r_deb_cnt;
   logic [c_hold_w-1:0] r_hold_cnt;

   // Two-flop synchroniser; resets to the released pin level so that reset
   // exit never looks like a press
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= {2{c_rel_lvl}};
      end else begin
         r_sync <= {r_sync[0], key_in};
      end
   end

   // Normalise stage: registered "pressed = 1" view of the synchronised pin
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_syn <= 1'b0;
      end else begin
         r_syn <= f_norm(r_sync[1], KEY_ACT_LOW);
      end
   end

   // Debounce: accept a new level only after DEB_CNT+1 consecutive
   // disagreeing cycles; any agreeing cycle restarts the window
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= 1'b0;
         r_deb_cnt <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         if (r_syn == r_state) begin
            r_deb_cnt <= '0;
         end else if (r_deb_cnt == c_deb_max) begin
            r_state   <= r_syn;
            r_deb_cnt <= '0;
            r_press   <= r_syn;
            r_release <= ~r_syn;
         end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
         end
      end
   end

   // Hold counter: counts pressed cycles and parks one above the threshold,
   // so the long pulse can fire only once per press
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_hold_cnt <= '0;
         r_long     <= 1'b0;
      end else begin
         r_long <= r_state && (r_hold_cnt == c_long_at);
         if (!r_state) begin
            r_hold_cnt <= '0;
         end else if (r_hold_cnt != c_hold_sat) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
         end
      end
   end

   assign key_state   = r_state;
   assign key_press   = r_press;
   assign key_release = r_release;
   assign key_long    = r_long;

endmodule : key_deb_ch
`default_nettype wire

// File: rtl/key_deb.sv
`default_nettype none
// ============================================================================
//  Module      : key_deb
//  Description : Multi-channel push-button conditioner. Each raw key pin is
//                synchronised, debounced and edge-detected independently,
//                giving a clean level plus press / release / long-press
//                single-cycle pulses in the system clock domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_deb
   import key_deb_pkg::*;
#(
   parameter int unsigned KEY_NUM     = 4,
   parameter int unsigned DEB_CNT     = c_deb_cnt,
   parameter int unsigned LONG_CNT    = c_long_cnt,
   parameter bit          KEY_ACT_LOW = c_key_act_low
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [KEY_NUM-1:0] key_in,
   output logic [KEY_NUM-1:0] key_state,
   output logic [KEY_NUM-1:0] key_press,
   output logic [KEY_NUM-1:0] key_release,
   output logic [KEY_NUM-1:0] key_long
);

   // One fully independent conditioner per key
   for (genvar gi = 0; gi < KEY_NUM; gi++) begin : g_ch
      key_deb_ch #(
         .DEB_CNT     (DEB_CNT),
         .LONG_CNT    (LONG_CNT),
         .KEY_ACT_LOW (KEY_ACT_LOW)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .key_in      (key_in[gi]),
         .key_state   (key_state[gi]),
         .key_press   (key_press[gi]),
         .key_release (key_release[gi]),
         .key_long    (key_long[gi])
      );
   end : g_ch

endmodule : key_deb
`default_nettype wire

// File: tb/tb_key_deb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_deb
//  Description : Self-checking bench for key_deb (DEB_CNT=9, LONG_CNT=49,
//                4 keys, active-low pins). A history/run-length model gives
//                the expected outputs every cycle; directed scenarios pin
//                latencies with literal cycle counts.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_deb;

   localparam int DEB = 9;
   localparam int LNG = 49;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] key_in;
   logic [3:0] key_state, key_press, key_release, key_long;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   key_deb #(
      .KEY_NUM     (4),
      .DEB_CNT     (DEB),
      .LONG_CNT    (LNG),
      .KEY_ACT_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long)
   );

   always #5 clk = ~clk;

   // Edge counter used to timestamp events
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A raw sample taken at edge n is first seen by the debounce decision at
   // edge n+3. The level flips once DEB+1 consecutive decisions disagree.
   // Long fires on the (LNG+1)th edge after the press edge while still held.
   logic [3:0] m_state = '0, m_press = '0, m_rel = '0, m_long = '0;
   logic [3:0] m_hist [3];
   int         m_run  [4];
   int         m_held [4];
   logic       m_syn, m_old;

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            m_state = '0; m_press = '0; m_rel = '0; m_long = '0;
            for (int c = 0; c < 4; c++) begin m_run[c] = 0; m_held[c] = 0; end
            for (int j = 0; j < 3; j++) m_hist[j] = 4'hF;
         end else begin
            for (int c = 0; c < 4; c++) begin
               m_syn = ~m_hist[0][c];
               m_old = m_state[c];
               m_press[c] = 1'b0;
               m_rel[c]   = 1'b0;
               if (m_old && m_held[c] < LNG + 2) m_held[c]++;
               m_long[c] = m_old && (m_held[c] == LNG + 1);
               if (m_syn != m_old) begin
                  m_run[c]++;
                  if (m_run[c] == DEB + 1) begin
                     m_state[c] = m_syn;
                     m_press[c] = m_syn;
                     m_rel[c]   = ~m_syn;
                     m_run[c]   = 0;
                  end
               end else begin
                  m_run[c] = 0;
               end
               if (!m_state[c]) m_held[c] = 0;
            end
            m_hist[0] = m_hist[1];
            m_hist[1] = m_hist[2];
            m_hist[2] = key_in;
         end
      end
   end

   // ---------------- per-cycle compare + event log ----------------
   int press_cnt[4], rel_cnt[4], long_cnt[4];
   int press_at[4], rel_at[4], long_at[4];

   initial begin
      for (int c = 0; c < 4; c++) begin
         press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
         press_at[c] = 0; rel_at[c] = 0; long_at[c] = 0;
      end
      forever begin
         @(negedge clk);
         chk("key_state",   key_state,   m_state);
         chk("key_press",   key_press,   m_press);
         chk("key_release", key_release, m_rel);
         chk("key_long",    key_long,    m_long);
         for (int c = 0; c < 4; c++) begin
            if (key_press[c]   === 1'b1) begin press_cnt[c]++; press_at[c] = cyc; end
            if (key_release[c] === 1'b1) begin rel_cnt[c]++;   rel_at[c]   = cyc; end
            if (key_long[c]    === 1'b1) begin long_cnt[c]++;  long_at[c]  = cyc; end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   function automatic int cnt_of(input int kind, input int c);
      case (kind)
         0:       return press_cnt[c];
         1:       return rel_cnt[c];
         default: return long_cnt[c];
      endcase
   endfunction

   // Bounded wait for an event count to reach target
   task automatic wait_evt(input int kind, input int c, input int target, input string name);
      int i;
      i = 0;
      while (cnt_of(kind, c) < target && i < 200) begin
         tick(1);
         i++;
      end
      chk(name, cnt_of(kind, c), target);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got no end expected end");
      $fatal(1, "timeout");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      int d, p, pc2, rc0, rc1;
      rst    = 1'b0;
      key_in = 4'b0000;
      tick(5);
      chk("reset_outputs", {key_state, key_press, key_release, key_long}, 32'h0);

      // Release reset with all keys up: nothing may happen
      key_in = 4'b1111;
      tick(1);
      rst = 1'b1;
      tick(100);
      chk("quiet_after_reset",
          press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] +
          rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3] +
          long_cnt[0] + long_cnt[1] + long_cnt[2] + long_cnt[3], 0);

      // Clean press on key 0: E = d+1, press at E+12
      key_in[0] = 1'b0;
      d = cyc;
      wait_evt(0, 0, 1, "clean_press_seen");
      chk("clean_press_latency", press_at[0] - (d + 1), 12);
      tick(3);
      chk("clean_press_once", press_cnt[0], 1);
      chk("clean_state", key_state[0], 1);

      // Bounce on key 1: low 5, high 1, then low for good
      key_in[1] = 1'b0;
      tick(5);
      key_in[1] = 1'b1;
      tick(1);
      key_in[1] = 1'b0;
      d = cyc;
      wait_evt(0, 1, 1, "bounce_press_seen");
      chk("bounce_latency", press_at[1] - (d + 1), 12);
      tick(5);
      chk("bounce_once", press_cnt[1], 1);

      // Long press on key 2, held 100 cycles past key_press
      key_in[2] = 1'b0;
      wait_evt(0, 2, 1, "long_press_seen");
      p = press_at[2];
      tick(p + 100 - cyc);
      chk("long_once", long_cnt[2], 1);
      chk("long_latency", long_at[2] - p, 50);
      key_in[2] = 1'b1;
      d = cyc;
      wait_evt(1, 2, 1, "long_release_seen");
      chk("release_latency", rel_at[2] - (d + 1), 12);

      // Short 30-cycle hold: release only, no long
      key_in[2] = 1'b0;
      wait_evt(0, 2, 2, "short_press_seen");
      tick(press_at[2] + 30 - cyc);
      key_in[2] = 1'b1;
      wait_evt(1, 2, 2, "short_release_seen");
      tick(60);
      chk("short_no_long", long_cnt[2], 1);

      // Set up: key 0 up, key 3 down
      key_in[0] = 1'b1;
      key_in[3] = 1'b0;
      wait_evt(1, 0, 1, "setup_rel0");
      wait_evt(0, 3, 1, "setup_press3");
      tick(5);
      // Same edge: press key 0, release key 3
      key_in[0] = 1'b0;
      key_in[3] = 1'b1;
      wait_evt(0, 0, 2, "simul_press0");
      wait_evt(1, 3, 1, "simul_rel3");
      chk("simul_same_cycle", rel_at[3] - press_at[0], 0);

      // Reset in the middle of a debounce window on key 2
      key_in[2] = 1'b0;
      tick(8);
      pc2 = press_cnt[2];
      rc0 = rel_cnt[0];
      rc1 = rel_cnt[1];
      rst = 1'b0;
      tick(1);
      chk("midreset_outputs", {key_state, key_press, key_release, key_long}, 32'h0);
      tick(3);
      chk("midreset_no_press", press_cnt[2], pc2);
      chk("midreset_no_release", rel_cnt[0] + rel_cnt[1], rc0 + rc1);
      rst = 1'b1;
      d = cyc;
      wait_evt(0, 2, pc2 + 1, "restart_press_seen");
      chk("restart_latency", press_at[2] - (d + 1), 12);

      // Let everything go and settle
      key_in = 4'b1111;
      tick(30);
      chk("final_state", key_state, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_key_deb
`default_nettype wire
